// File: rtl/dmem_pkg.sv
// Shared funct3 constants, FSM state type and funct3 legality check for dmem_responder.
// Used by the top level and by the lane-alignment helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Stores only have signed encodings; unsigned widths exist for loads only.
    function automatic logic legal_f3(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables / replicated write lanes, and
// load extraction with sign or zero extension. Expects an already-aligned i_addr_lo.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wlanes,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        o_be     = 4'b1111;
        o_wlanes = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be     = 4'b0001 << i_addr_lo;
                o_wlanes = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wlanes = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be     = 4'b1111;
                o_wlanes = i_wdata;
            end
        endcase
    end

    assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

    always_comb begin
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_rdata = {24'h000000, w_shifted[7:0]};
            F3_HU:   o_rdata = {16'h0000, w_shifted[15:0]};
            default: o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states for RV32I loads/stores.
// Define DMEM_MISALIGN_ERR_EN to report misaligned H/W accesses as errors instead of aligning down.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);
    localparam logic [29:0]   DEPTH_L  = 30'(DEPTH_WORDS);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_f3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_commit;
    logic          w_oor;
    logic          w_misalign;
    logic          w_err;
    logic          w_is_h;
    logic          w_is_w;
    logic [1:0]    w_addr_lo;
    logic [IW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [31:0]   w_wlanes;
    logic [31:0]   w_load;
    logic [3:0]    w_be;

    assign w_accept = req_valid && req_ready;
    assign w_commit = (r_state == WAIT) && (r_cnt == '0);
    assign w_oor    = r_addr[31:2] >= DEPTH_L;
    assign w_idx    = r_addr[IW+1:2];
    assign w_rword  = w_oor ? 32'h0 : r_mem[w_idx];
    assign w_is_h   = (r_f3 == F3_H) || (r_f3 == F3_HU);
    assign w_is_w   = (r_f3 == F3_W);

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_misalign = (w_is_h && r_addr[0]) || (w_is_w && (r_addr[1:0] != 2'b00));
    assign w_addr_lo  = r_addr[1:0];
`else
    assign w_misalign = 1'b0;
    assign w_addr_lo  = w_is_w ? 2'b00 : (w_is_h ? {r_addr[1], 1'b0} : r_addr[1:0]);
`endif

    assign w_err = w_oor || w_misalign || !legal_f3(r_we, r_f3);

    dmem_lane_align u_align (
        .i_funct3  (r_f3),
        .i_addr_lo (w_addr_lo),
        .i_wdata   (r_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wlanes  (w_wlanes),
        .o_rdata   (w_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = WAIT;
            WAIT:    if (r_cnt == '0) w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE) && !rst;
        rsp_valid = (r_state == RESP);
        busy      = (r_state != IDLE);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

    // Request latch, wait counter and response registers; response only changes on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_we) ? 32'h0 : w_load;
            end
        end
    end

    // Array is deliberately not reset; a store only lands on an error-free commit.
    always_ff @(posedge clk) begin
        if (w_commit && r_we && !w_err && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

endmodule
